// File: rtl/burst_ram_arbiter.sv
// Two-requester front end for a burst RAM: grants one requester, issues one burst command and streams/collects BURST_COUNT words.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN for fixed priority (requester 0 wins); otherwise arbitration is round-robin.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_0,
    input  logic                                 we_0,
    input  logic [DEPTH_BITWIDTH-1:0]            addr_0,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0] wdata_0,
    input  logic                                 req_1,
    input  logic                                 we_1,
    input  logic [DEPTH_BITWIDTH-1:0]            addr_1,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0] wdata_1,
    output logic                                 ack_0,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0] rdata_0,
    output logic                                 ack_1,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0] rdata_1,
    output logic                                 ram_cmd,
    output logic                                 ram_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]            ram_addr,
    output logic [DATA_BITWIDTH-1:0]             ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]           ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]             ram_rd_data,
    input  logic                                 ram_rd_data_valid,
    input  logic                                 ram_busy
);
    localparam int BUS_W = BURST_COUNT * DATA_BITWIDTH;
    localparam int CNT_W = $clog2(BURST_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(BURST_COUNT);

    typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_WAIT, DONE} state_t;

    state_t                    r_state;
    logic                      r_sel;
    logic [CNT_W-1:0]          r_cnt;
    logic [BUS_W-1:0]          r_wbuf;
    logic [BUS_W-1:0]          r_rbuf;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    logic                      r_last;
`endif
    logic                      w_grant;
    logic                      w_pick;
    logic                      w_we;
    logic [DEPTH_BITWIDTH-1:0] w_addr;
    logic [BUS_W-1:0]          w_wdata;
    logic [BUS_W-1:0]          w_rfull;

    always_comb begin
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        w_pick = ~req_0;
`else
        // Both requesting: the one not served last; otherwise whoever is asking.
        w_pick = (req_0 && req_1) ? ~r_last : ~req_0;
`endif
        w_grant = (r_state == IDLE) && !ram_busy && (req_0 || req_1);
        w_we    = w_pick ? we_1 : we_0;
        w_addr  = w_pick ? addr_1 : addr_0;
        w_wdata = w_pick ? wdata_1 : wdata_0;
        w_rfull = r_rbuf;
        w_rfull[int'(r_cnt)*DATA_BITWIDTH +: DATA_BITWIDTH] = ram_rd_data;
    end

    always_ff @(posedge clk) begin
        if (w_grant)
            r_wbuf <= w_wdata;
        if (r_state == READ_WAIT && ram_rd_data_valid)
            r_rbuf <= w_rfull;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sel         <= 1'b0;
            r_cnt         <= '0;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            r_last        <= 1'b1;
`endif
            ram_cmd_en    <= 1'b0;
            ram_cmd       <= 1'b0;
            ram_addr      <= '0;
            ram_wr_data   <= '0;
            ram_data_mask <= '0;
            ack_0         <= 1'b0;
            ack_1         <= 1'b0;
            rdata_0       <= '0;
            rdata_1       <= '0;
        end else begin
            ram_cmd_en <= 1'b0;
            ack_0      <= 1'b0;
            ack_1      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_sel       <= w_pick;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
                        r_last      <= w_pick;
`endif
                        ram_cmd_en  <= 1'b1;
                        ram_cmd     <= w_we;
                        ram_addr    <= w_addr;
                        ram_wr_data <= w_wdata[DATA_BITWIDTH-1:0];
                        r_cnt       <= w_we ? CNT_W'(1) : '0;
                        r_state     <= w_we ? WRITE_BURST : READ_WAIT;
                    end
                end
                WRITE_BURST: begin
                    if (r_cnt == ALL_WORDS) begin
                        ack_0   <= ~r_sel;
                        ack_1   <= r_sel;
                        r_state <= DONE;
                    end else begin
                        ram_wr_data <= r_wbuf[int'(r_cnt)*DATA_BITWIDTH +: DATA_BITWIDTH];
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (ram_rd_data_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            if (r_sel)
                                rdata_1 <= w_rfull;
                            else
                                rdata_0 <= w_rfull;
                            ack_0   <= ~r_sel;
                            ack_1   <= r_sel;
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: a burst RAM stand-in plus a transaction-level reference model of arbitration, timing and data.
module tb_burst_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int BC = 4;
    localparam int BW = DW * BC;

    logic          clk, rst;
    logic          req_0, we_0, req_1, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [BW-1:0] wdata_0, wdata_1;
    logic          ack_0, ack_1;
    logic [BW-1:0] rdata_0, rdata_1;
    logic          ram_cmd, ram_cmd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW/8-1:0] ram_data_mask;
    logic [DW-1:0] ram_rd_data;
    logic          ram_rd_data_valid, ram_busy;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ref_mem [16];
    logic [BW-1:0] ref_rd [2];
    int            last_g;
    bit            act [2];
    bit            gap_mode;
    int            rd_words_sent;
    int            last_valid_cyc;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_0(ack_0), .rdata_0(rdata_0), .ack_1(ack_1), .rdata_1(rdata_1),
        .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
        .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid), .ram_busy(ram_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] r;
        for (int i = 0; i < BW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference arbitration rule.
    function automatic int pick(bit a0, bit a1);
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        return a0 ? 0 : 1;
`else
        if (a0 && a1) return (last_g == 1) ? 0 : 1;
        return a0 ? 0 : 1;
`endif
    endfunction

    task automatic start_req(input int n, input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        if (n == 0) begin
            req_0 = 1'b1; we_0 = w; addr_0 = a; wdata_0 = d;
        end else begin
            req_1 = 1'b1; we_1 = w; addr_1 = a; wdata_1 = d;
        end
        act[n] = 1'b1;
    endtask

    // Burst RAM stand-in: 8-cycle read delay, optional gaps between read words.
    initial begin
        logic [AW-1:0] a;
        ram_rd_data_valid = 1'b0;
        ram_rd_data = '0;
        forever begin
            @(negedge clk);
            if (ram_cmd_en === 1'b1) begin
                a = ram_addr;
                if (ram_cmd) begin
                    ram_mem[a] = ram_wr_data;
                    for (int k = 1; k < BC; k++) begin
                        @(negedge clk);
                        ram_mem[(int'(a) + k) % 16] = ram_wr_data;
                    end
                end else begin
                    repeat (8) @(negedge clk);
                    for (int k = 0; k < BC; k++) begin
                        @(negedge clk);
                        if (k > 0 && gap_mode) begin
                            ram_rd_data_valid = 1'b0;
                            ram_rd_data = {$urandom, $urandom};
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                        end
                        ram_rd_data = ram_mem[(int'(a) + k) % 16];
                        ram_rd_data_valid = 1'b1;
                        rd_words_sent++;
                        if (k == BC - 1) last_valid_cyc = cyc;
                    end
                    @(negedge clk);
                    ram_rd_data_valid = 1'b0;
                    ram_rd_data = {$urandom, $urandom};
                end
            end
        end
    end

    // Follow one granted transaction to its ack, checking bus timing and data.
    task automatic serve(input int g, output int t_cmd);
        logic          w;
        logic [AW-1:0] a;
        logic [BW-1:0] wd;
        bit            seen;
        int            extra_cmd;
        w  = g ? we_1 : we_0;
        a  = g ? addr_1 : addr_0;
        wd = g ? wdata_1 : wdata_0;
        seen = 1'b0;
        t_cmd = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ram_cmd_en) seen = 1'b1;
        end
        chk("cmd_issued", seen, 1);
        if (!seen) begin
            req_0 = 1'b0; req_1 = 1'b0; act[0] = 1'b0; act[1] = 1'b0;
            return;
        end
        t_cmd = cyc;
        last_g = g;
        chk("cmd_we", ram_cmd, w);
        chk("cmd_addr", ram_addr, a);
        chk("wr_word0", ram_wr_data, wd[DW-1:0]);
        if (w) begin
            for (int k = 1; k < BC; k++) begin
                @(negedge clk);
                chk("cmd_en_single", ram_cmd_en, 0);
                chk("wr_word", ram_wr_data, wd[k*DW +: DW]);
            end
            @(negedge clk);
            for (int k = 0; k < BC; k++) ref_mem[(int'(a) + k) % 16] = wd[k*DW +: DW];
        end else begin
            seen = 1'b0;
            extra_cmd = 0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (ram_cmd_en) extra_cmd++;
                if (ack_0 || ack_1) seen = 1'b1;
            end
            chk("rd_ack_seen", seen, 1);
            chk("rd_no_extra_cmd", extra_cmd, 0);
            chk("rd_ack_after_last_word", cyc, last_valid_cyc + 1);
            if (!gap_mode) chk("rd_latency", cyc - t_cmd, 13);
            for (int k = 0; k < BC; k++) ref_rd[g][k*DW +: DW] = ref_mem[(int'(a) + k) % 16];
        end
        chk("ack_granted", g ? ack_1 : ack_0, 1);
        chk("ack_other", g ? ack_0 : ack_1, 0);
        chk("rdata_0", rdata_0, ref_rd[0]);
        chk("rdata_1", rdata_1, ref_rd[1]);
        if (g == 1) req_1 = 1'b0; else req_0 = 1'b0;
        act[g] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", ack_0 | ack_1, 0);
    endtask

    initial begin
        int            tc, g, b, cnt, acks;
        logic [BW-1:0] wsave;
        rst = 1'b1;
        req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0;
        req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; wdata_1 = '0;
        ram_busy = 1'b0;
        gap_mode = 1'b0;
        last_g = 1;
        act[0] = 1'b0; act[1] = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        rd_words_sent = 0;
        last_valid_cyc = 0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = {$urandom, $urandom};
            ref_mem[i] = ram_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_cmd_en", ram_cmd_en, 0);
        chk("rst_cmd", ram_cmd, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wr_data", ram_wr_data, 0);
        chk("rst_ack", {ack_1, ack_0}, 0);
        chk("rst_rdata_0", rdata_0, 0);
        chk("rst_rdata_1", rdata_1, 0);
        chk("rst_mask", ram_data_mask, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back through requester 0, then a read through requester 1.
        wsave = rand_bus();
        start_req(0, 1'b1, 4'd4, wsave);
        serve(pick(act[0], act[1]), tc);
        start_req(0, 1'b0, 4'd4, '0);
        serve(pick(act[0], act[1]), tc);
        chk("readback", rdata_0, wsave);
        start_req(1, 1'b0, 4'd0, '0);
        serve(pick(act[0], act[1]), tc);

        // Both requesters kept busy.
        start_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
        start_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
        for (int t = 0; t < 4; t++) begin
            g = pick(act[0], act[1]);
            serve(g, tc);
            start_req(g, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
        end
        while (act[0] || act[1]) serve(pick(act[0], act[1]), tc);

        // Busy RAM holds off the command.
        ram_busy = 1'b1;
        start_req(0, 1'b1, AW'($urandom_range(0, 15)), rand_bus());
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_cmd_en) cnt++;
        end
        chk("busy_blocks_cmd", cnt, 0);
        ram_busy = 1'b0;
        b = cyc;
        serve(pick(act[0], act[1]), tc);
        chk("cmd_after_busy", tc, b + 1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if (!act[0] && $urandom_range(0, 1) == 1)
                start_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
            if (!act[1] && $urandom_range(0, 1) == 1)
                start_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
            if (!act[0] && !act[1])
                start_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rand_bus());
            gap_mode = 1'($urandom_range(0, 1));
            serve(pick(act[0], act[1]), tc);
        end
        while (act[0] || act[1]) serve(pick(act[0], act[1]), tc);

        // Reset in the middle of a read burst.
        gap_mode = 1'b0;
        cnt = rd_words_sent;
        start_req(0, 1'b0, AW'($urandom_range(0, 15)), '0);
        for (int i = 0; i < 100 && rd_words_sent < cnt + 2; i++) @(posedge clk);
        chk("words_before_reset", rd_words_sent >= cnt + 2, 1);
        #2;
        rst = 1'b1;
        req_0 = 1'b0;
        act[0] = 1'b0;
        @(negedge clk);
        chk("midrst_ack", {ack_1, ack_0}, 0);
        chk("midrst_rdata_0", rdata_0, 0);
        chk("midrst_cmd_en", ram_cmd_en, 0);
        rst = 1'b0;
        last_g = 1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        acks = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack_0 || ack_1) acks++;
        end
        chk("no_ack_after_reset", acks, 0);
        chk("rdata_0_after_reset", rdata_0, 0);
        start_req(0, 1'b0, AW'($urandom_range(0, 15)), '0);
        start_req(1, 1'b1, AW'($urandom_range(0, 15)), rand_bus());
        while (act[0] || act[1]) serve(pick(act[0], act[1]), tc);
        chk("mask_zero", ram_data_mask, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
